ntt_controller: RTL and testbench
=================================

// Module: ntt_controller
// PURPOSE
//   Global sequencer for the 257-bank non-power-of-two NTT datapath; one address per bank, 256 rows per bank.
//   After start it runs a prime-permutation pass (RPP), eight radix-2 butterfly stages (BF0..BF7) and a merge pass (MRG).
//   It drives crossbar shifts, per-bank read/write addresses, write enables, unit opcodes and twiddle indices.
//   It pulses done when the transform has finished.
// PARAMETERS
//   LANES   257  number of memory banks / datapath lanes
//   AW      8    bank address width (256 rows)
//   WR_LAT  6    cycles from read issue to write-back (datapath pipeline depth)
//   NUM_MOD 48   number of supported moduli; valid mod_idx range is 1..NUM_MOD-1
// PORTS
//   clk          in   1          rising-edge clock
//   reset        in   1          asynchronous, active-high reset
//   start        in   1          one-cycle request to begin a transform
//   mod_idx      in   6          modulus select, sampled with start
//   cs1_shift    out  9          read-crossbar rotation, 0..256
//   cs2_shift    out  9          write-crossbar rotation, 0..256
//   addr_read    out  LANES*AW   lane i read address in bits [8i+7:8i]
//   addr_write   out  LANES*AW   lane i write address, same packing
//   we           out  LANES      per-bank write enable
//   rpp_op       out  2          prime-permutation unit op: 00 idle, 01 active
//   brp_op       out  3          bit-reverse permutation op: 000 idle, 001 butterfly route, 100 bit-reverse
//   bfa_mode     out  1          butterfly array mode: 1 butterfly, 0 pass/mult-add
//   bfa_swap     out  1          butterfly operand slot: 0 upper (A), 1 lower (B)
//   bfa_w_idx    out  11         twiddle ROM index
//   merge_sel    out  3          merge mux select: 0 idle, 1 merge
//   add_b_in_sel out  2          adder B-input select: 00 zero, 01 RPP, 10 merge
//   done         out  1          one-cycle completion pulse
// BEHAVIOUR
//   - Reset: async, active-high. State=IDLE, counters=0, write pipe cleared; every output is 0.
//   - FSM: IDLE -> RPP -> FL -> BF(s=0) -> FL -> ... -> BF(7) -> FL -> MRG -> FL -> DONE -> IDLE.
//   - Start acceptance: start is accepted only in IDLE with 1<=mod_idx<NUM_MOD. mod_idx is then latched in mod_q.
//   - Ignored starts: start in any other state, or with an out-of-range mod_idx, has no effect.
//   - Phase counter: cnt runs 0..255, one row per cycle, in RPP, BF and MRG.
//   - FL state: waits WR_LAT cycles with no reads. It drains the write pipe to prevent read-after-write hazards.
//   - RPP, per lane i: read addr=(cnt+i) mod 256.
//     cs1_shift=cnt, cs2_shift=(257-cnt) mod 257.
//     rpp_op=01, add_b_in_sel=01, bfa_mode=0.
//   - BF stage s: p=cnt>>1, h=2^s, a=((p>>s)<<(s+1)) | (p mod h).
//     All lanes read row a when cnt[0]=0 and row a+h when cnt[0]=1. bfa_swap=cnt[0].
//     bfa_mode=1, brp_op=001, cs shifts 0.
//     bfa_w_idx={s[2:0], ((p mod h)<<(7-s))[7:0]}.
//   - MRG: all lanes read bitrev8(cnt). brp_op=100, merge_sel=1, add_b_in_sel=10.
//   - Fields not listed for a state are 0, including every field in IDLE, FL and DONE.
//   - Write path: the read address vector and a read-valid bit pass through a WR_LAT-deep shift register.
//     addr_write = delayed read addresses; we = all LANES bits set when the delayed valid is 1, else 0.
//     cs2_shift is applied with the read-side value (the datapath aligns it).
//   - DONE: done=1 for exactly one cycle, then IDLE. A start in that cycle is ignored.
//   - Runtime: 10*256 + 10*WR_LAT + 1 cycles from start to done (2621 with defaults).
//   - Reset mid-run: everything aborts immediately to reset values, with no done pulse.
// TESTING
//   1. Reset held -> all outputs 0. Release, no start -> outputs stay 0 and done stays 0.
//   2. start=1, mod_idx=1 -> RPP cycle 0: lane 0 addr 0, lane 5 addr 5, cs1=0.
//      RPP cnt=3: cs1=3, cs2=254, lane 256 addr 3.
//      First we=all-ones exactly WR_LAT cycles after the first read.
//   3. BF s=2, cnt=9 (p=4, lower slot): all lanes read row 12, bfa_swap=1, bfa_w_idx=11'b010_00000000.
//      BF s=2, cnt=10 (p=5): all lanes read row 9, bfa_w_idx=11'b010_00100000.
//   4. MRG cnt=1 -> all lanes read addr 128, merge_sel=1, brp_op=100.
//      done pulses once, 2621 cycles after start, then IDLE.
//   5. start with mod_idx=0 or 48 -> no activity. start during BF3 -> schedule unchanged.
//   6. Reset asserted during BF4 -> outputs 0 asynchronously, no done. A new start then runs the full sequence.

Source files
------------

// File: rtl/ntt_controller.sv
// ntt_controller
//   Global sequencer for the 257-bank NTT datapath. A start runs these passes in order:
//   a prime-permutation pass (RPP), eight radix-2 butterfly stages (BF0..BF7) and a
//   merge pass (MRG). Each pass is followed by a flush (FL), and a one-cycle done pulse ends
//   the transform.
// Ports
//   clk, reset            clock, async active-high reset
//   start, mod_idx        transform request and modulus select (sampled together)
//   cs1_shift, cs2_shift  read/write crossbar rotations
//   addr_read/addr_write  per-lane row addresses, lane i in bits [8i+7:8i]
//   we                    per-bank write enable
//   rpp_op, brp_op, bfa_mode, bfa_swap, bfa_w_idx, merge_sel, add_b_in_sel
//                         datapath unit controls
//   done                  one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for a valid start
// RPP   | prime-permutation pass, 256 rows
// FL    | WR_LAT-cycle drain of the write pipe, no reads
// BF    | butterfly stage s = ph-1, 256 cycles (128 row pairs)
// MRG   | merge pass, bit-reversed row order
// DONE  | done pulse, back to IDLE
module ntt_controller #(
  parameter int LANES   = 257,
  parameter int AW      = 8,
  parameter int WR_LAT  = 6,
  parameter int NUM_MOD = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [5:0]            mod_idx,
  output logic [8:0]            cs1_shift,
  output logic [8:0]            cs2_shift,
  output logic [LANES*AW-1:0]   addr_read,
  output logic [LANES*AW-1:0]   addr_write,
  output logic [LANES-1:0]      we,
  output logic [1:0]            rpp_op,
  output logic [2:0]            brp_op,
  output logic                  bfa_mode,
  output logic                  bfa_swap,
  output logic [10:0]           bfa_w_idx,
  output logic [2:0]            merge_sel,
  output logic [1:0]            add_b_in_sel,
  output logic                  done
);

  typedef enum logic [2:0] {S_IDLE, S_RPP, S_FL, S_BF, S_MRG, S_DONE} state_t;

  localparam int FW = $clog2(WR_LAT + 1);
  localparam logic [FW-1:0] FL_LOAD = FW'(WR_LAT - 1);
  localparam logic [3:0] LAST_PH = 4'd9;

  state_t state, n_state;
  logic [AW-1:0] cnt, n_cnt;
  logic [3:0] ph, n_ph;            // 0 = RPP, 1..8 = BF0..BF7, 9 = MRG
  logic [FW-1:0] fl_cnt, n_fl;
  logic [5:0] mod_q, n_mod;

  logic [LANES*AW-1:0] ap [WR_LAT];
  logic [WR_LAT-1:0] vp;
  logic rd_valid;

  // next-state decode
  always_comb begin
    n_state = state;
    n_cnt   = cnt;
    n_ph    = ph;
    n_fl    = fl_cnt;
    n_mod   = mod_q;
    case (state)
      S_IDLE: if (start && mod_idx != 6'd0 && int'(mod_idx) < NUM_MOD) begin
        n_state = S_RPP;
        n_cnt   = '0;
        n_ph    = 4'd0;
        n_mod   = mod_idx;
      end
      S_RPP, S_BF, S_MRG: begin
        if (cnt == {AW{1'b1}}) begin
          n_state = S_FL;
          n_fl    = FL_LOAD;
        end else begin
          n_cnt = cnt + 1'b1;
        end
      end
      S_FL: begin
        if (fl_cnt == '0) begin
          n_cnt = '0;
          if (ph == LAST_PH) begin
            n_state = S_DONE;
          end else begin
            n_ph    = ph + 4'd1;
            n_state = (ph == LAST_PH - 4'd1) ? S_MRG : S_BF;
          end
        end else begin
          n_fl = fl_cnt - 1'b1;
        end
      end
      S_DONE:  n_state = S_IDLE;
      default: n_state = S_IDLE;
    endcase
  end

  // butterfly addressing from the next-cycle counters so the outputs can be registered
  logic [2:0] s;
  logic [6:0] p;
  logic [7:0] h, lo, a, row_bf, w_lo, rev;
  always_comb begin
    s      = 3'(n_ph - 4'd1);
    p      = n_cnt[7:1];
    h      = 8'd1 << s;
    lo     = {1'b0, p} & (h - 8'd1);
    a      = (({1'b0, p} >> s) << (4'(s) + 4'd1)) | lo;
    row_bf = a + (n_cnt[0] ? h : 8'd0);
    w_lo   = lo << (3'd7 - s);
    for (int b = 0; b < 8; b++) rev[b] = n_cnt[7-b];
  end

  logic [LANES*AW-1:0] d_rd;
  logic [8:0] d_cs1, d_cs2;
  logic [1:0] d_rpp, d_addb;
  logic [2:0] d_brp, d_merge;
  logic d_mode, d_swap, d_done, d_valid;
  logic [10:0] d_widx;
  always_comb begin
    d_rd = '0; d_cs1 = '0; d_cs2 = '0; d_rpp = '0; d_addb = '0;
    d_brp = '0; d_merge = '0; d_mode = 1'b0; d_swap = 1'b0;
    d_done = 1'b0; d_valid = 1'b0; d_widx = '0;
    case (n_state)
      S_RPP: begin
        for (int i = 0; i < LANES; i++) d_rd[i*AW +: AW] = n_cnt + AW'(i);
        d_cs1   = {1'b0, n_cnt};
        d_cs2   = (n_cnt == '0) ? 9'd0 : 9'd257 - {1'b0, n_cnt};
        d_rpp   = 2'b01;
        d_addb  = 2'b01;
        d_valid = 1'b1;
      end
      S_BF: begin
        d_rd    = {LANES{row_bf}};
        d_brp   = 3'b001;
        d_mode  = 1'b1;
        d_swap  = n_cnt[0];
        d_widx  = {s, w_lo};
        d_valid = 1'b1;
      end
      S_MRG: begin
        d_rd    = {LANES{rev}};
        d_brp   = 3'b100;
        d_merge = 3'd1;
        d_addb  = 2'b10;
        d_valid = 1'b1;
      end
      S_DONE:  d_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ph           <= '0;
      fl_cnt       <= '0;
      mod_q        <= '0;
      addr_read    <= '0;
      cs1_shift    <= '0;
      cs2_shift    <= '0;
      rpp_op       <= '0;
      brp_op       <= '0;
      bfa_mode     <= 1'b0;
      bfa_swap     <= 1'b0;
      bfa_w_idx    <= '0;
      merge_sel    <= '0;
      add_b_in_sel <= '0;
      done         <= 1'b0;
      rd_valid     <= 1'b0;
      vp           <= '0;
      for (int j = 0; j < WR_LAT; j++) ap[j] <= '0;
    end else begin
      state        <= n_state;
      cnt          <= n_cnt;
      ph           <= n_ph;
      fl_cnt       <= n_fl;
      mod_q        <= n_mod;
      addr_read    <= d_rd;
      cs1_shift    <= d_cs1;
      cs2_shift    <= d_cs2;
      rpp_op       <= d_rpp;
      brp_op       <= d_brp;
      bfa_mode     <= d_mode;
      bfa_swap     <= d_swap;
      bfa_w_idx    <= d_widx;
      merge_sel    <= d_merge;
      add_b_in_sel <= d_addb;
      done         <= d_done;
      rd_valid     <= d_valid;
      // write pipe taps the registered read side, so stage WR_LAT-1 lags it by WR_LAT cycles
      ap[0]        <= addr_read;
      for (int j = 1; j < WR_LAT; j++) ap[j] <= ap[j-1];
      vp           <= {vp[WR_LAT-2:0], rd_valid};
    end
  end

  assign addr_write = ap[WR_LAT-1];
  assign we         = {LANES{vp[WR_LAT-1]}};

endmodule

// File: tb/tb_ntt_controller.sv
module tb_ntt_controller;
  localparam int LANES  = 257;
  localparam int AW     = 8;
  localparam int WR_LAT = 6;
  localparam int PER    = 256 + WR_LAT;
  localparam int RUN    = 10 * 256 + 10 * WR_LAT + 1;

  logic clk = 1'b0;
  logic reset, start;
  logic [5:0] mod_idx;
  logic [8:0] cs1_shift, cs2_shift;
  logic [LANES*AW-1:0] addr_read, addr_write;
  logic [LANES-1:0] we;
  logic [1:0] rpp_op, add_b_in_sel;
  logic [2:0] brp_op, merge_sel;
  logic bfa_mode, bfa_swap, done;
  logic [10:0] bfa_w_idx;

  ntt_controller dut (
    .clk(clk), .reset(reset), .start(start), .mod_idx(mod_idx),
    .cs1_shift(cs1_shift), .cs2_shift(cs2_shift),
    .addr_read(addr_read), .addr_write(addr_write), .we(we),
    .rpp_op(rpp_op), .brp_op(brp_op), .bfa_mode(bfa_mode), .bfa_swap(bfa_swap),
    .bfa_w_idx(bfa_w_idx), .merge_sel(merge_sel), .add_b_in_sel(add_b_in_sel),
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] l0;
    logic [7:0] l5;
    logic [7:0] l256;
  } wexp_t;
  wexp_t wq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_act(input int j);
    return j >= 0 && (j / PER) < 10 && (j % PER) < 256;
  endfunction

  // expected row of a lane, j = clock edges since the edge that accepted start
  function automatic logic [7:0] exp_lane(input int j, input int lane);
    int ph, c, s, h, p, a, r;
    if (!is_act(j)) return 8'd0;
    ph = j / PER;
    c  = j % PER;
    if (ph == 0) return 8'((c + lane) % 256);
    if (ph <= 8) begin
      s = ph - 1;
      h = 1 << s;
      p = c / 2;
      a = (p / h) * 2 * h + p % h;
      return 8'(a + (c % 2) * h);
    end
    r = 0;
    for (int b = 0; b < 8; b++) if (((c >> b) & 1) == 1) r = r + (1 << (7 - b));
    return 8'(r);
  endfunction

  function automatic logic [41:0] exp_ctrl(input int j);
    logic [8:0] e_cs1, e_cs2;
    logic [1:0] e_rpp, e_addb;
    logic [2:0] e_brp, e_merge;
    logic e_mode, e_swap, e_done;
    logic [10:0] e_widx;
    int ph, c, s, h, p;
    e_cs1 = '0; e_cs2 = '0; e_rpp = '0; e_addb = '0; e_brp = '0; e_merge = '0;
    e_mode = 1'b0; e_swap = 1'b0; e_done = 1'b0; e_widx = '0;
    if (is_act(j)) begin
      ph = j / PER;
      c  = j % PER;
      if (ph == 0) begin
        e_cs1 = 9'(c);
        e_cs2 = 9'((257 - c) % 257);
        e_rpp = 2'b01;
        e_addb = 2'b01;
      end else if (ph <= 8) begin
        s = ph - 1;
        h = 1 << s;
        p = c / 2;
        e_brp = 3'b001;
        e_mode = 1'b1;
        e_swap = 1'(c % 2);
        e_widx = 11'(s * 256 + (p % h) * (128 / h));
      end else begin
        e_brp = 3'b100;
        e_merge = 3'd1;
        e_addb = 2'b10;
      end
    end
    if (j == RUN - 1) e_done = 1'b1;
    return {e_cs1, e_cs2, e_rpp, e_brp, e_mode, e_swap, e_widx, e_merge, e_addb, e_done};
  endfunction

  function automatic bit all_zero();
    return addr_read == '0 && addr_write == '0 && we == '0 && cs1_shift == '0 &&
           cs2_shift == '0 && rpp_op == '0 && brp_op == '0 && !bfa_mode && !bfa_swap &&
           bfa_w_idx == '0 && merge_sel == '0 && add_b_in_sel == '0 && !done;
  endfunction

  // Starts a transform and checks every cycle against the model. Returns early after
  // cycle stop_j; a second start is driven at inject_j.
  task automatic run_seq(input int stop_j, input int inject_j);
    int dcount;
    wexp_t item, got;
    logic [41:0] ctrl_obs;
    dcount = 0;
    wq.delete();
    @(negedge clk);
    start = 1'b1;
    mod_idx = 6'd1;
    for (int j = 0; j < RUN; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (j == inject_j) begin
        start = 1'b1;
        mod_idx = 6'd5;
      end
      if (j == RUN - 1) begin
        start = 1'b1;
        mod_idx = 6'd1;
      end
      ctrl_obs = {cs1_shift, cs2_shift, rpp_op, brp_op, bfa_mode, bfa_swap,
                  bfa_w_idx, merge_sel, add_b_in_sel, done};
      chk("ctrl", 64'(ctrl_obs), 64'(exp_ctrl(j)));
      chk("rd_l0", 64'(addr_read[0 +: 8]), 64'(exp_lane(j, 0)));
      chk("rd_l5", 64'(addr_read[5*8 +: 8]), 64'(exp_lane(j, 5)));
      chk("rd_l256", 64'(addr_read[256*8 +: 8]), 64'(exp_lane(j, 256)));
      chk("we", 64'({&we, |we}), is_act(j - WR_LAT) ? 64'd3 : 64'd0);
      if (is_act(j)) begin
        item.l0 = exp_lane(j, 0);
        item.l5 = exp_lane(j, 5);
        item.l256 = exp_lane(j, 256);
        wq.push_back(item);
      end
      if (|we) begin
        if (wq.size() == 0) begin
          chk("wq_underflow", 64'd1, 64'd0);
        end else begin
          item = wq.pop_front();
          got.l0 = addr_write[0 +: 8];
          got.l5 = addr_write[5*8 +: 8];
          got.l256 = addr_write[256*8 +: 8];
          chk("wr_addr", 64'({got.l0, got.l5, got.l256}), 64'({item.l0, item.l5, item.l256}));
        end
      end
      if (done) dcount++;
      case (j)
        0: chk("rpp0_lane5", 64'(addr_read[5*8 +: 8]), 64'd5);
        3: chk("rpp3_cs", 64'({cs1_shift, cs2_shift, addr_read[256*8 +: 8]}),
               64'({9'd3, 9'd254, 8'd3}));
        WR_LAT - 1: chk("pre_first_we", 64'(|we), 64'd0);
        WR_LAT: chk("first_we", 64'(&we), 64'd1);
        3*PER + 9: chk("bf2_c9", 64'({addr_read[100*8 +: 8], bfa_swap, bfa_w_idx}),
                       64'({8'd12, 1'b1, 11'b010_00000000}));
        3*PER + 10: chk("bf2_c10", 64'({addr_read[100*8 +: 8], bfa_w_idx}),
                        64'({8'd9, 11'b010_00100000}));
        9*PER + 1: chk("mrg_c1", 64'({addr_read[200*8 +: 8], merge_sel, brp_op}),
                       64'({8'd128, 3'd1, 3'b100}));
        RUN - 1: chk("done_at_2621", 64'(done), 64'd1);
        default: ;
      endcase
      if (j == stop_j) return;
    end
    @(negedge clk);
    start = 1'b0;
    chk("idle_after_done", 64'(all_zero()), 64'd1);
    chk("done_count", 64'(dcount), 64'd1);
    chk("wq_left", 64'(wq.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mod_idx = 6'd0;
    repeat (3) @(negedge clk);
    chk("reset_zero", 64'(all_zero()), 64'd1);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_zero", 64'(all_zero()), 64'd1);
    end

    // out-of-range moduli must not start anything
    @(negedge clk); start = 1'b1; mod_idx = 6'd0;
    @(negedge clk); start = 1'b0;
    repeat (4) begin
      chk("mod0_ignored", 64'(all_zero()), 64'd1);
      @(negedge clk);
    end
    start = 1'b1; mod_idx = 6'd48;
    @(negedge clk); start = 1'b0;
    repeat (4) begin
      chk("mod48_ignored", 64'(all_zero()), 64'd1);
      @(negedge clk);
    end

    // full run with a stray start during BF3
    run_seq(RUN, 4*PER + 20);

    // abort during BF4
    run_seq(5*PER + 30, -1);
    #3 reset = 1'b1;
    #1 chk("async_reset", 64'(all_zero()), 64'd1);
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", 64'(all_zero()), 64'd1);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("no_done_after_abort", 64'(done), 64'd0);

    run_seq(RUN, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
